// File: rtl/logic_loom_fib.sv
// Free-running 8-bit Fibonacci generator with a programmable term limit.
// Exposes a registered sliding window F(k), F(k+1), F(k+2) and the step count k.
module logic_loom_fib (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] n,
  output logic [7:0] fib0,
  output logic [7:0] fib1,
  output logic [7:0] fib2,
  output logic [7:0] count
);

  logic [7:0] r_fib0;
  logic [7:0] r_fib1;
  logic [7:0] r_fib2;
  logic [7:0] r_count;
  logic       w_advance;

  // count is bounded by n (at most 255), so the increment can never wrap.
  assign w_advance = (r_count < n);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge window and the whole window shifts in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fib0  <= 8'd0;
      r_fib1  <= 8'd1;
      r_fib2  <= 8'd1;
      r_count <= 8'd0;
    end else if (w_advance) begin
      r_fib0  <= r_fib1;
      r_fib1  <= r_fib2;
      r_fib2  <= r_fib1 + r_fib2;
      r_count <= r_count + 8'd1;
    end
  end

  assign fib0  = r_fib0;
  assign fib1  = r_fib1;
  assign fib2  = r_fib2;
  assign count = r_count;

endmodule

// File: tb/tb_logic_loom_fib.sv
// Directed bench for logic_loom_fib: a reference model pushes the expected
// window per edge into a scoreboard queue, popped and compared after the edge.
module tb_logic_loom_fib;

  typedef struct {
    logic [7:0] f0;
    logic [7:0] f1;
    logic [7:0] f2;
    logic [7:0] c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] n;
  logic [7:0] fib0;
  logic [7:0] fib1;
  logic [7:0] fib2;
  logic [7:0] count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic [7:0] m0, m1, m2, mc;

  logic_loom_fib dut (
    .clk   (clk),
    .rst   (rst),
    .n     (n),
    .fib0  (fib0),
    .fib1  (fib1),
    .fib2  (fib2),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] ec);
    check({tag, ".fib0"},  fib0,  e0);
    check({tag, ".fib1"},  fib1,  e1);
    check({tag, ".fib2"},  fib2,  e2);
    check({tag, ".count"}, count, ec);
  endtask

  task automatic model_reset();
    m0 = 8'd0; m1 = 8'd1; m2 = 8'd1; mc = 8'd0;
  endtask

  // Advance the model, queue its expectation, clock once, then score it.
  task automatic step(input string tag);
    exp_t e;
    logic [7:0] nxt;
    if (mc < n) begin
      nxt = m1 + m2;
      m0  = m1;
      m1  = m2;
      m2  = nxt;
      mc  = mc + 8'd1;
    end
    sb_q.push_back('{f0: m0, f1: m1, f2: m2, c: mc});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_now(tag, e.f0, e.f1, e.f2, e.c);
    end
  endtask

  // Called just after an edge, so assertion and release land mid-cycle.
  task automatic do_reset(input logic [7:0] nval);
    rst = 1'b1;
    #1;
    n   = nval;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    n   = 8'd10;
    model_reset();

    // Reset is asynchronous: values must be present before any clock edge.
    #3;
    check_now("reset_async", 8'd0, 8'd1, 8'd1, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    check_now("reset_held", 8'd0, 8'd1, 8'd1, 8'd0);

    // Full run to n=10, then hold.
    rst = 1'b0;
    step("run10_e1");
    check_now("run10_e1_lit", 8'd1, 8'd1, 8'd2, 8'd1);
    for (int i = 2; i <= 10; i++) step($sformatf("run10_e%0d", i));
    check_now("run10_e10_lit", 8'd55, 8'd89, 8'd144, 8'd10);
    step("run10_e11");
    step("run10_e12");
    check_now("run10_hold_lit", 8'd55, 8'd89, 8'd144, 8'd10);

    // Zero limit never advances.
    do_reset(8'd0);
    for (int i = 1; i <= 5; i++) step($sformatf("zero_e%0d", i));
    check_now("zero_lit", 8'd0, 8'd1, 8'd1, 8'd0);

    // Wrap-around past F(13)=233.
    do_reset(8'd14);
    for (int i = 1; i <= 12; i++) step($sformatf("wrap_e%0d", i));
    check_now("wrap_c12_lit", 8'd144, 8'd233, 8'd121, 8'd12);
    step("wrap_e13");
    step("wrap_e14");
    check_now("wrap_c14_lit", 8'd121, 8'd98, 8'd219, 8'd14);
    step("wrap_hold1");
    step("wrap_hold2");

    // Limit raised mid-run resumes; lowering below count freezes.
    do_reset(8'd3);
    for (int i = 1; i <= 4; i++) step($sformatf("lim3_e%0d", i));
    check_now("lim3_hold_lit", 8'd2, 8'd3, 8'd5, 8'd3);
    n = 8'd5;
    step("lim5_e1");
    step("lim5_e2");
    check_now("lim5_lit", 8'd5, 8'd8, 8'd13, 8'd5);
    step("lim5_hold");
    n = 8'd20;
    step("lim20_e1");
    n = 8'd2;
    step("lower_freeze1");
    step("lower_freeze2");
    check_now("lower_lit", 8'd8, 8'd13, 8'd21, 8'd6);

    // Mid-run reset pulse between edges.
    do_reset(8'd10);
    for (int i = 1; i <= 4; i++) step($sformatf("mid_e%0d", i));
    check_now("mid_c4_lit", 8'd3, 8'd5, 8'd8, 8'd4);
    rst = 1'b1;
    #1;
    check_now("mid_rst_async", 8'd0, 8'd1, 8'd1, 8'd0);
    #1;
    rst = 1'b0;
    model_reset();
    step("mid_restart");
    check_now("mid_restart_lit", 8'd1, 8'd1, 8'd2, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
